// File: rtl/pin_array_pkg.sv
// Shared constants, width helper and pointer type for the pin-array deserialiser.
package pin_array_pkg;

  localparam int NCH_DEF   = 4;
  localparam int DEPTH_DEF = 2;

  // Bit width needed to index n items, never less than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  typedef logic [clog2_min1(DEPTH_DEF)-1:0] fifo_ptr_t;

endpackage

// File: rtl/pin_array_fifo.sv
// Small synchronous word FIFO with flush, registered head word and a
// simultaneous push/pop path that stays accepted while full.
module pin_array_fifo
  import pin_array_pkg::*;
#(
  parameter int W     = NCH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PW = clog2_min1(DEPTH);
  localparam int CW = clog2_min1(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;

  logic [W-1:0]  mem_q [DEPTH];
  ptr_t          rd_q, rd_d;
  ptr_t          wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  head_q, head_d;
  logic          push_ok, pop_ok;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign head    = head_q;
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    head_d = head_q;
    if (clr) begin
      rd_d   = '0;
      wr_d   = '0;
      cnt_d  = '0;
      head_d = '0;
    end else begin
      if (pop_ok)  rd_d = ptr_inc(rd_q);
      if (push_ok) wr_d = ptr_inc(wr_q);
      case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      // The head register must be loaded straight from din when the word
      // being pushed becomes the new head, since it is not in mem_q yet.
      if (cnt_d == '0)
        head_d = '0;
      else if (push_ok && (cnt_q == '0 || (pop_ok && cnt_q == CW'(1))))
        head_d = din;
      else
        head_d = mem_q[rd_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem_q[wr_q] <= din;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

endmodule

// File: rtl/pin_array_deser.sv
// Serial-to-parallel pin array: NCH capture slices feeding a word FIFO.
// Optional even-parity sideband on the head word with PIN_ARRAY_DESER_PARITY_EN.
module pin_array_deser
  import pin_array_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic           clk,
  input  logic           rstb,
  input  logic           VDD,
  input  logic           VSS,
  input  logic           vin,
  input  logic           vin_valid,
  input  logic           clr,
  output logic [NCH-1:0] mid,
  output logic [NCH-1:0] vout,
  output logic           vout_valid,
  input  logic           vout_ready,
  output logic           ovf
`ifdef PIN_ARRAY_DESER_PARITY_EN
  ,
  output logic           vout_par
`endif
);

  localparam int SW = clog2_min1(NCH);
`ifdef PIN_ARRAY_DESER_PARITY_EN
  localparam int FW = NCH + 1;
`else
  localparam int FW = NCH;
`endif

  logic [SW-1:0]  slot_q, slot_d;
  logic [NCH-1:0] mid_q, mid_d;
  logic           ovf_q, ovf_d;
  logic           word_done;
  logic           pop;
  logic           fifo_full, fifo_empty;
  logic [NCH-1:0] word;
  logic [FW-1:0]  fifo_din, fifo_head;

  // Power pins exist only for netlist compatibility.
  logic unused_pwr;
  assign unused_pwr = VDD ^ VSS;

  assign word_done = vin_valid && (slot_q == SW'(NCH - 1));
  assign word      = {vin, mid_q[NCH-2:0]};
  assign pop       = !fifo_empty && vout_ready;

`ifdef PIN_ARRAY_DESER_PARITY_EN
  assign fifo_din = {^word, word};
  assign vout_par = fifo_head[NCH];
`else
  assign fifo_din = word;
`endif

  always_comb begin
    slot_d = slot_q;
    mid_d  = mid_q;
    ovf_d  = ovf_q;
    if (clr) begin
      slot_d = '0;
      mid_d  = '0;
      ovf_d  = 1'b0;
    end else if (vin_valid) begin
      mid_d[slot_q] = vin;
      slot_d        = word_done ? '0 : slot_q + 1'b1;
      if (word_done && fifo_full && !pop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      slot_q <= '0;
      mid_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      slot_q <= slot_d;
      mid_q  <= mid_d;
      ovf_q  <= ovf_d;
    end
  end

  pin_array_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstb  (rstb),
    .clr   (clr),
    .push  (word_done),
    .pop   (pop),
    .din   (fifo_din),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign mid        = mid_q;
  assign vout       = fifo_head[NCH-1:0];
  assign vout_valid = !fifo_empty;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_pin_array_deser.sv
// Self-checking bench for pin_array_deser (NCH=4, DEPTH=2) with a queue-based
// reference model; parity checks follow PIN_ARRAY_DESER_PARITY_EN.
module tb_pin_array_deser;

  localparam int NCH   = 4;
  localparam int DEPTH = 2;

  logic           clk = 1'b0;
  logic           rstb = 1'b0;
  logic           VDD = 1'b1;
  logic           VSS = 1'b0;
  logic           vin = 1'b0;
  logic           vin_valid = 1'b0;
  logic           clr = 1'b0;
  logic           vout_ready = 1'b0;
  logic [NCH-1:0] mid, vout;
  logic           vout_valid, ovf;
`ifdef PIN_ARRAY_DESER_PARITY_EN
  logic           vout_par;
`endif

  always #5 clk = ~clk;

  pin_array_deser #(.NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .VDD        (VDD),
    .VSS        (VSS),
    .vin        (vin),
    .vin_valid  (vin_valid),
    .clr        (clr),
    .mid        (mid),
    .vout       (vout),
    .vout_valid (vout_valid),
    .vout_ready (vout_ready),
    .ovf        (ovf)
`ifdef PIN_ARRAY_DESER_PARITY_EN
    ,
    .vout_par   (vout_par)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: collected sample bits, queue of whole words, sticky flag.
  int             nb;
  logic [NCH-1:0] m_mid;
  logic [NCH-1:0] mq[$];
  bit             m_ovf;
  logic [NCH-1:0] e_vout;
  logic           e_vv;

  function automatic void model_reset();
    nb    = 0;
    m_mid = '0;
    mq.delete();
    m_ovf = 1'b0;
    e_vout = '0;
    e_vv   = 1'b0;
  endfunction

  function automatic void model_step();
    logic [NCH-1:0] dropped;
    if (clr) begin
      nb    = 0;
      m_mid = '0;
      mq.delete();
      m_ovf = 1'b0;
      return;
    end
    if (mq.size() != 0 && vout_ready) dropped = mq.pop_front();
    if (vin_valid) begin
      m_mid[nb] = vin;
      nb++;
      if (nb == NCH) begin
        nb = 0;
        if (mq.size() < DEPTH) mq.push_back(m_mid);
        else m_ovf = 1'b1;
      end
    end
  endfunction

  function automatic void model_outputs();
    e_vv   = (mq.size() != 0);
    e_vout = e_vv ? mq[0] : '0;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    model_outputs();
  endtask

  task automatic send_word(input logic [NCH-1:0] w);
    for (int i = 0; i < NCH; i++) begin
      vin       = w[i];
      vin_valid = 1'b1;
      tick();
    end
    vin_valid = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({mid, vout, vout_valid, ovf} !== '0)
      $display("FAIL reset_hold got mid=%h vout=%h vv=%b ovf=%b want all 0", mid, vout, vout_valid, ovf);
    else n_pass++;
    #4 rstb = 1'b1;
    model_reset();
    tick();
    n_total++;
    if ({mid, vout, vout_valid, ovf} !== '0 || dut.slot_q !== '0)
      $display("FAIL reset_release got mid=%h vout=%h vv=%b ovf=%b slot=%0d want all 0",
               mid, vout, vout_valid, ovf, dut.slot_q);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [NCH-1:0] bits;
    logic [NCH-1:0] exp_mid [4];
    bits = 4'b1101;
    exp_mid = '{4'b0001, 4'b0001, 4'b0101, 4'b1101};
    vout_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      vin       = bits[i];
      vin_valid = 1'b1;
      tick();
      n_total++;
      if (mid !== exp_mid[i] || vout_valid !== (i == NCH - 1) || mid !== m_mid)
        $display("FAIL basic_step%0d got mid=%b vv=%b want mid=%b vv=%b", i, mid, vout_valid,
                 exp_mid[i], (i == NCH - 1));
      else n_pass++;
    end
    n_total++;
    if (vout !== 4'hD || vout !== e_vout)
      $display("FAIL basic_word got %h want %h", vout, 4'hD);
    else n_pass++;
    vin_valid = 1'b0;
    tick();
    n_total++;
    if (vout_valid !== 1'b0 || vout !== 4'h0)
      $display("FAIL basic_one_cycle got vv=%b vout=%h want vv=0 vout=0", vout_valid, vout);
    else n_pass++;
  endtask

  task automatic test_overflow();
    vout_ready = 1'b0;
    do_clr();
    send_word(4'h1);
    send_word(4'h2);
    send_word(4'h3);
    n_total++;
    if (vout !== 4'h1 || vout_valid !== 1'b1 || ovf !== 1'b1)
      $display("FAIL ovf_full got vout=%h vv=%b ovf=%b want 1 1 1", vout, vout_valid, ovf);
    else n_pass++;
    vout_ready = 1'b1;
    tick();
    n_total++;
    if (vout !== 4'h2 || vout_valid !== 1'b1 || vout !== e_vout)
      $display("FAIL ovf_pop1 got vout=%h vv=%b want 2 1", vout, vout_valid);
    else n_pass++;
    tick();
    n_total++;
    if (vout_valid !== 1'b0 || vout !== 4'h0 || ovf !== 1'b1 || ovf !== m_ovf)
      $display("FAIL ovf_drain got vout=%h vv=%b ovf=%b want 0 0 1", vout, vout_valid, ovf);
    else n_pass++;
  endtask

  task automatic test_full_push_pop();
    logic [NCH-1:0] c;
    c = 4'hC;
    vout_ready = 1'b0;
    do_clr();
    send_word(4'hA);
    send_word(4'h5);
    for (int i = 0; i < NCH; i++) begin
      vin        = c[i];
      vin_valid  = 1'b1;
      vout_ready = (i == NCH - 1);
      tick();
    end
    vin_valid = 1'b0;
    n_total++;
    if (ovf !== 1'b0 || vout !== 4'h5 || vout_valid !== 1'b1)
      $display("FAIL fullpp_push got vout=%h vv=%b ovf=%b want 5 1 0", vout, vout_valid, ovf);
    else n_pass++;
    vout_ready = 1'b1;
    tick();
    n_total++;
    if (vout !== 4'hC || vout_valid !== 1'b1)
      $display("FAIL fullpp_kept got vout=%h vv=%b want C 1", vout, vout_valid);
    else n_pass++;
    tick();
    n_total++;
    if (vout_valid !== 1'b0 || ovf !== 1'b0)
      $display("FAIL fullpp_empty got vv=%b ovf=%b want 0 0", vout_valid, ovf);
    else n_pass++;
  endtask

  task automatic test_gaps();
    logic [6:0] vv_seq;
    logic [6:0] vin_seq;
    vv_seq  = 7'b1101001;
    vin_seq = 7'b1101001;
    vout_ready = 1'b0;
    do_clr();
    for (int i = 0; i < 7; i++) begin
      vin_valid = vv_seq[i];
      vin       = vv_seq[i] ? vin_seq[i] : 1'($urandom_range(0, 1));
      tick();
    end
    vin_valid = 1'b0;
    n_total++;
    if (vout !== 4'hF || vout_valid !== 1'b1 || dut.slot_q !== '0 || nb != 0)
      $display("FAIL gaps got vout=%h vv=%b slot=%0d want F 1 0", vout, vout_valid, dut.slot_q);
    else n_pass++;
  endtask

  task automatic test_clr();
    vout_ready = 1'b0;
    do_clr();
    send_word(4'h3);
    send_word(4'h4);
    send_word(4'h6);
    vin = 1'b1;
    vin_valid = 1'b1;
    tick();
    tick();
    vin_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_total++;
    if ({mid, vout, vout_valid, ovf} !== '0)
      $display("FAIL clr_flush got mid=%h vout=%h vv=%b ovf=%b want all 0", mid, vout, vout_valid, ovf);
    else n_pass++;
    send_word(4'h9);
    n_total++;
    if (vout !== 4'h9 || vout_valid !== 1'b1 || ovf !== 1'b0 || mid !== 4'h9)
      $display("FAIL clr_next got vout=%h vv=%b ovf=%b mid=%h want 9 1 0 9", vout, vout_valid, ovf, mid);
    else n_pass++;
  endtask

  task automatic test_rstb();
    vout_ready = 1'b0;
    send_word(4'h7);
    vin = 1'b1;
    vin_valid = 1'b1;
    tick();
    tick();
    vin_valid = 1'b0;
    #1 rstb = 1'b0;
    #1;
    n_total++;
    if ({mid, vout, vout_valid, ovf} !== '0)
      $display("FAIL rstb_async got mid=%h vout=%h vv=%b ovf=%b want all 0", mid, vout, vout_valid, ovf);
    else n_pass++;
    model_reset();
    #2 rstb = 1'b1;
    send_word(4'hB);
    n_total++;
    if (vout !== 4'hB || vout_valid !== 1'b1 || vout !== e_vout)
      $display("FAIL rstb_next got vout=%h vv=%b want B 1", vout, vout_valid);
    else n_pass++;
  endtask

`ifdef PIN_ARRAY_DESER_PARITY_EN
  task automatic test_parity();
    vout_ready = 1'b0;
    do_clr();
    send_word(4'h7);
    send_word(4'h3);
    n_total++;
    if (vout_par !== 1'b1)
      $display("FAIL par_7 got %b want 1", vout_par);
    else n_pass++;
    vout_ready = 1'b1;
    tick();
    n_total++;
    if (vout_par !== 1'b0 || vout !== 4'h3)
      $display("FAIL par_3 got par=%b vout=%h want 0 3", vout_par, vout);
    else n_pass++;
    tick();
    n_total++;
    if (vout_par !== 1'b0 || vout_valid !== 1'b0)
      $display("FAIL par_empty got par=%b vv=%b want 0 0", vout_par, vout_valid);
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    int errs;
    errs = 0;
    do_clr();
    for (int cyc = 0; cyc < 600; cyc++) begin
      vin        = 1'($urandom_range(0, 1));
      vin_valid  = ($urandom_range(0, 3) != 0);
      vout_ready = 1'($urandom_range(0, 1));
      clr        = ($urandom_range(0, 49) == 0);
      tick();
      n_total++;
      if ({mid, vout, vout_valid, ovf} !== {m_mid, e_vout, e_vv, m_ovf}) begin
        if (errs < 10)
          $display("FAIL rand cyc=%0d got mid=%h vout=%h vv=%b ovf=%b want mid=%h vout=%h vv=%b ovf=%b",
                   cyc, mid, vout, vout_valid, ovf, m_mid, e_vout, e_vv, m_ovf);
        errs++;
      end else n_pass++;
`ifdef PIN_ARRAY_DESER_PARITY_EN
      n_total++;
      if (vout_par !== (^e_vout))
        $display("FAIL rand_par cyc=%0d got %b want %b", cyc, vout_par, ^e_vout);
      else n_pass++;
`endif
    end
    clr = 1'b0;
    vin_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_gaps();
    test_clr();
    test_rstb();
`ifdef PIN_ARRAY_DESER_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
